// File: rtl/usb_pkg.sv
// Shared USB definitions used by the endpoint FIFO, AHB slave, receiver and transmitter.
package usb_pkg;

  typedef logic [7:0] usb_byte_t;

  localparam int USB_FIFO_DEPTH = 64;
  localparam int USB_OCC_W      = 7;

  typedef logic [USB_OCC_W-1:0] usb_occ_t;

endpackage

// File: rtl/usb_fifo_mem.sv
// DEPTH x 8 storage with one synchronous write port and one asynchronous read port; contents are never reset.
module usb_fifo_mem
  import usb_pkg::*;
#(
  parameter int DEPTH = USB_FIFO_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  usb_byte_t       wr_data,
  input  logic [AW-1:0]   rd_addr,
  output usb_byte_t       rd_data
);

  usb_byte_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/usb_endpoint_fifo.sv
// Shared endpoint byte FIFO: two push sources, two pop sinks, show-ahead read, occupancy and error pulses.
module usb_endpoint_fifo
  import usb_pkg::*;
#(
  parameter int DEPTH = USB_FIFO_DEPTH
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        store_tx_data,
  input  logic [7:0]  tx_data,
  input  logic        store_rx_packet_data,
  input  logic [7:0]  rx_packet_data,
  input  logic        get_rx_data,
  output logic [7:0]  rx_data,
  input  logic        get_tx_packet_data,
  output logic [7:0]  tx_packet_data,
  input  logic        clear,
  input  logic        flush,
  output logic [6:0]  buffer_occupancy,
  output logic        overflow,
  output logic        underflow
);

  localparam int       AW         = $clog2(DEPTH);
  localparam usb_occ_t FULL_COUNT = usb_occ_t'(DEPTH);

  // Strobes are fire-and-forget: a push or pop acts on the edge where it is high,
  // with no ready back-pressure; refused requests are reported via overflow/underflow.
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  usb_occ_t      count;
  logic          push;
  logic          pop;
  logic          push_ok;
  logic          pop_ok;
  logic          do_clear;
  logic          empty;
  logic          full;
  logic          overflow_next;
  logic          underflow_next;
  usb_byte_t     push_data;
  usb_byte_t     head;

  assign push      = store_tx_data | store_rx_packet_data;
  assign pop       = get_rx_data | get_tx_packet_data;
  assign push_data = store_rx_packet_data ? rx_packet_data : tx_data;
  assign do_clear  = clear | flush;
  assign empty     = (count == '0);
  assign full      = (count == FULL_COUNT);

  // At full a simultaneous pop frees the slot being written, so the push is kept.
  assign pop_ok  = pop & ~empty & ~do_clear;
  assign push_ok = push & (~full | pop) & ~do_clear;

  assign overflow_next  = ~do_clear &
                          ((store_tx_data & store_rx_packet_data) | (push & full & ~pop));
  assign underflow_next = ~do_clear & pop & empty;

  usb_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push_ok),
    .wr_addr (wr_ptr),
    .wr_data (push_data),
    .rd_addr (rd_ptr),
    .rd_data (head)
  );

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (do_clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= overflow_next;
      underflow <= underflow_next;
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rx_data          = empty ? 8'h00 : head;
  assign tx_packet_data   = empty ? 8'h00 : head;
  assign buffer_occupancy = count;

endmodule
